cpu_muldiv_unit: RTL and testbench
==================================

// Module: cpu_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the CPU execute stage, fed by register-bank read ports rd1/rd2.
//  Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per clock: radix-2 shift-add multiply, restoring divide.
//  Returns result plus destination tag; control FSM writes it back via register-bank port 3 (wen3/a3/wd3).
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  ADDR_WIDTH  5   destination register tag width (matches register bank)
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            reset, asynchronous, active-low
//  start        in   1            request; sampled only in IDLE
//  flush        in   1            synchronous abort of the in-flight operation
//  funct3       in   3            op select, RV32M encoding
//  op_a         in   DATA_WIDTH   rs1 value (register bank rd1)
//  op_b         in   DATA_WIDTH   rs2 value (register bank rd2)
//  rd_in        in   ADDR_WIDTH   destination register tag
//  busy         out  1            high in CALC and DONE
//  valid        out  1            one-cycle pulse, result/rd_out valid
//  result       out  DATA_WIDTH   final result; held until next accepted start
//  rd_out       out  ADDR_WIDTH   tag captured at start
// BEHAVIOUR
//  Reset (async): state=IDLE; busy, valid, result, rd_out, counter, internal regs = 0.
//  FSM: IDLE -> CALC (start, normal op) | DONE (start, special case) ; CALC -> DONE after DATA_WIDTH iterations ; DONE -> IDLE.
//  Timing: start high in cycle 0 (IDLE): operands, funct3 and rd_in latched at end of cycle 0.
//   Normal: CALC in cycles 1..DATA_WIDTH; DONE and valid=1 in cycle DATA_WIDTH+1 (33 at default).
//   Special: DONE and valid=1 in cycle 1.
//  start outside IDLE is ignored; no queueing. flush has priority over start.
//  flush in CALC/DONE: IDLE at next edge, valid never asserted, result keeps its previous value.
//  flush in IDLE: no effect; a start in the same cycle is dropped.
//  Signs: signed operands converted to magnitude at latch; unsigned core; result negated when signs require.
//   MULH: signed x signed; MULHSU: signed op_a x unsigned op_b; MULHU: unsigned; MUL: low word.
//   Product is 2*DATA_WIDTH bits; MUL returns [W-1:0], MULH* return [2W-1:W].
//   DIV/REM round toward zero; remainder takes dividend sign.
//  Special cases, no iteration, result computed at latch:
//   op_b==0: DIV/DIVU -> all ones; REM/REMU -> op_a.
//   DIV op_a==-2^(W-1), op_b==-1 -> -2^(W-1); REM -> 0.
//  Counter: $clog2(DATA_WIDTH)+1 bits, cleared at latch, DONE entered when it reaches DATA_WIDTH.
//  result/rd_out update only on entry to DONE.
//  Async reset mid-operation: immediate IDLE, all outputs 0.
//  SVA:
//   warning on start while busy;
//   error if valid lasts more than 1 cycle;
//   error if busy && state==IDLE.
// STRUCTURE
//  pkg_cpu_typedefs gets:
//   muldiv_op_e: MUL=3'b000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111.
//   muldiv_state_e: IDLE, CALC, DONE.
//  Single module, no sub-module. One shared accumulator/shift datapath serves both multiply and divide.
// TESTING
//  MUL op_a=7, op_b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, valid in cycle 33, busy cycles 1..33.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF(-1) x 2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIVU 100/0 -> 0xFFFFFFFF, REMU 100/0 -> 100, DIV 0x80000000/-1 -> 0x80000000, REM same operands -> 0.
//   All special cases give valid in cycle 1.
//  Flush at cycle 10 of MUL: busy low cycle 11, no valid pulse, result unchanged.
//   New start in cycle 11 completes normally in cycle 44.
//  Start pulsed in cycle 5 during CALC: ignored, rd_out keeps first tag.
//   rst_n low at cycle 20: outputs 0 immediately; next start works from IDLE.

Source files
------------

// File: rtl/cpu_muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: op encoding and control states.
package pkg_cpu_typedefs;

  // RV32M funct3 encoding; bit 2 set selects the divide family.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/cpu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per clock over a shared
// accumulator, shift-add multiply and restoring divide on operand magnitudes.
module cpu_muldiv_unit
  import pkg_cpu_typedefs::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [ADDR_WIDTH-1:0] rd_in,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] rd_out
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned P_W   = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  muldiv_state_e    state;
  muldiv_op_e       op_q;
  logic [W-1:0]     acc_hi;
  logic [W-1:0]     acc_lo;
  logic [W-1:0]     opb_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_WIDTH-1:0] rd_q;

  muldiv_op_e in_op;
  logic       a_signed, b_signed;
  logic       a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic       in_is_div, in_is_rem;
  logic       div_zero, div_ovf, special;
  logic       in_neg;
  logic [W-1:0] special_res;

  logic [W:0]   add_a, add_b, add_cin, add_sum;
  logic [W-1:0] step_hi, step_lo;
  logic [CNT_W-1:0] cnt_nxt;
  logic [P_W-1:0] prod_abs, prod_sgn;
  logic [W-1:0] final_res;

  assign in_op     = muldiv_op_e'(funct3);
  assign in_is_div = funct3[2];
  assign in_is_rem = funct3[1];

  // Which operands are treated as signed for the requested op.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (in_op)
      MULH, DIV, REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MULHSU:  a_signed = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes, special-case detection and result sign at latch time.
  always_comb begin
    a_neg    = a_signed & op_a[W-1];
    b_neg    = b_signed & op_b[W-1];
    a_mag    = a_neg ? (W'(0) - op_a) : op_a;
    b_mag    = b_neg ? (W'(0) - op_b) : op_b;
    div_zero = in_is_div && (op_b == '0);
    div_ovf  = a_signed && in_is_div &&
               (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == {W{1'b1}});
    special  = div_zero | div_ovf;
    if (in_is_div && in_is_rem) in_neg = a_neg;
    else                        in_neg = a_neg ^ b_neg;
    if (div_zero) special_res = in_is_rem ? op_a : {W{1'b1}};
    else          special_res = in_is_rem ? '0 : op_a;
  end

  // One shared adder: accumulate multiplicand, or trial-subtract the divisor.
  always_comb begin
    if (!op_q[2]) begin
      add_a   = {1'b0, acc_hi};
      add_b   = acc_lo[0] ? {1'b0, opb_q} : '0;
      add_cin = '0;
    end else begin
      add_a   = {acc_hi, acc_lo[W-1]};
      add_b   = ~{1'b0, opb_q};
      add_cin = (W+1)'(1);
    end
    add_sum = add_a + add_b + add_cin;
  end

  // Next accumulator state for one iteration.
  always_comb begin
    if (!op_q[2]) begin
      step_hi = add_sum[W:1];
      step_lo = {add_sum[0], acc_lo[W-1:1]};
    end else if (add_sum[W]) begin
      step_hi = add_a[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b0};
    end else begin
      step_hi = add_sum[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b1};
    end
    cnt_nxt = cnt + CNT_W'(1);
  end

  // Sign fix-up and word selection of the completed iteration.
  always_comb begin
    prod_abs = {step_hi, step_lo};
    prod_sgn = neg_q ? (P_W'(0) - prod_abs) : prod_abs;
    case (op_q)
      MUL:                 final_res = prod_sgn[W-1:0];
      MULH, MULHSU, MULHU: final_res = prod_sgn[P_W-1:W];
      DIV, DIVU:           final_res = neg_q ? (W'(0) - step_lo) : step_lo;
      default:             final_res = neg_q ? (W'(0) - step_hi) : step_hi;
    endcase
  end

  // Control FSM, operand latch, iteration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= MUL;
      acc_hi <= '0;
      acc_lo <= '0;
      opb_q  <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      rd_q   <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q   <= in_op;
            acc_hi <= '0;
            acc_lo <= a_mag;
            opb_q  <= b_mag;
            neg_q  <= in_neg;
            cnt    <= '0;
            rd_q   <= rd_in;
            busy   <= 1'b1;
            if (special) begin
              state  <= DONE;
              valid  <= 1'b1;
              result <= special_res;
              rd_out <= rd_in;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt_nxt;
            if (cnt_nxt == CNT_W'(W)) begin
              state  <= DONE;
              valid  <= 1'b1;
              result <= final_res;
              rd_out <= rd_q;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Protocol checks.
  a_start_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start && busy))
    else $warning("cpu_muldiv_unit: start ignored while busy");
  a_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n) valid |=> !valid)
    else $error("cpu_muldiv_unit: valid held longer than one cycle");
  a_busy_idle: assert property (@(posedge clk) disable iff (!rst_n) !(busy && state == IDLE))
    else $error("cpu_muldiv_unit: busy asserted in IDLE");

endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// Scoreboard bench for cpu_muldiv_unit: directed RV32M vectors, flush, ignored start, mid-op reset.
module tb_cpu_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  cpu_muldiv_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .valid(valid),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_valid = 0;
  int          cyc = 0;
  logic [31:0] last_exp = '0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                         F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                         F_REM = 3'b110, F_REMU = 3'b111;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse is matched against the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: result 0x%08h rd %0d with nothing expected", result, rd_out);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_valid(input int base);
    int i;
    i = 0;
    while (n_valid == base && i < 60) begin
      @(posedge clk);
      i++;
    end
    if (n_valid == base) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no valid within 60 cycles, got none expected one");
      sb.delete();
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    exp_t e;
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    e.res = exp; e.rd = rd; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int base;
    @(posedge clk); #1;
    base = n_valid;
    issue(f, a, b, rd, exp, lat);
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(base);
    last_exp = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int base;
    logic busy_ok;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_rd_out", 32'(rd_out), 32'h0);
    rst_n = 1'b1;

    // MUL with busy window checked cycle by cycle.
    @(posedge clk); #1;
    c0 = cyc;
    base = n_valid;
    issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33);
    @(negedge clk);
    chk("busy_cycle0", 32'(busy), 32'h0);
    busy_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (i < 33) @(posedge clk);
    end
    chk("busy_window", 32'(busy_ok), 32'h1);
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'h0);
    if (n_valid == base) begin
      n_vec++; n_err++;
      $display("FAIL mul_valid: got no valid expected one by cycle %0d", c0 + 33);
      sb.delete();
    end
    last_exp = 32'hFFFF_FFEB;

    // Multiply family and divide family, normal iteration.
    run_op(F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33);
    run_op(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
    run_op(F_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, 33);
    run_op(F_MUL,    32'h1234_5678, 32'h10,        5'd5,  32'h2345_6780, 33);
    run_op(F_DIV,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33);
    run_op(F_REM,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33);
    run_op(F_DIVU,   32'd100,       32'd7,         5'd8,  32'd14,        33);
    run_op(F_REMU,   32'd100,       32'd7,         5'd9,  32'd2,         33);
    run_op(F_DIV,    32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
    run_op(F_REM,    32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1,         33);
    run_op(F_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd12, 32'hFFFF_FFFF, 33);

    // Special cases finish in cycle 1.
    run_op(F_DIVU, 32'd100,       32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run_op(F_REMU, 32'd100,       32'd0,         5'd14, 32'd100,       1);
    run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0,         1);

    // Flush in cycle 10 of a MUL, restart in cycle 11.
    @(posedge clk); #1;
    c0 = cyc;
    funct3 = F_MUL; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    base = n_valid;
    issue(F_MUL, 32'd3, 32'd4, 5'd21, 32'd12, 33);
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_result", result, last_exp);
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(base);
    last_exp = 32'd12;

    // Start pulsed during CALC is ignored.
    @(posedge clk); #1;
    base = n_valid;
    issue(F_MUL, 32'd9, 32'd9, 5'd22, 32'd81, 33);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    funct3 = F_DIVU; op_a = 32'd1; op_b = 32'd0; rd_in = 5'd30; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ignored_start_busy", 32'(busy), 32'h1);
    wait_valid(base);

    // Asynchronous reset in cycle 20 of a MUL.
    @(posedge clk); #1;
    funct3 = F_MUL; op_a = 32'd11; op_b = 32'd11; rd_in = 5'd23; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_rd_out", 32'(rd_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd24, 32'hFFFF_FFEB, 33);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
